crono_bcd_n: RTL and testbench

- Parametrised successor to the team's 4-digit stopwatch.
- N-digit BCD stopwatch with an internal tick prescaler, synchronised and edge-detected push-buttons, and a prioritised four-state controller (IDLE/RUN/LAP/STOP).
- LAP freezes the display while counting continues. STOP freezes both and can resume.
- Feeds the 7-segment decoder stage. One digit per 4-bit nibble, digit 0 is the least significant.

---
 rtl/crono_bcd_n.sv | 209 ++++++++++++++++++++
 tb/tb_crono_bcd_n.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crono_bcd_n.sv
// N-digit BCD stopwatch: tick prescaler, synchronised edge-detected buttons, IDLE/RUN/LAP/STOP control.
// Optional countdown (down_mode/preset ports) is built when CRONO_COUNTDOWN_EN is defined.
module crono_bcd_n #(
    parameter int N_DIGITS  = 4,
    parameter int TICK_DIV  = 1,
    parameter int WRAP_MODE = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  btn_start,
    input  logic                  btn_lap,
    input  logic                  btn_stop,
    input  logic                  btn_clear,
`ifdef CRONO_COUNTDOWN_EN
    input  logic                  down_mode,
    input  logic [4*N_DIGITS-1:0] preset,
`endif
    output logic [4*N_DIGITS-1:0] digits,
    output logic [4*N_DIGITS-1:0] count,
    output logic [1:0]            state,
    output logic                  ovf
);
    localparam int W  = 4 * N_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, STOP = 2'd3} state_e;
    typedef enum logic [2:0] {CMD_NONE, CMD_START, CMD_LAP, CMD_STOP, CMD_CLEAR} cmd_e;

    state_e        state_q, state_d;
    cmd_e          cmd;
    logic [3:0]    btn_raw, sync1_q, sync2_q, prev_q, press;
    logic [W-1:0]  count_q, count_d, digits_q, digits_d, inc, dec;
    logic [PW-1:0] presc_q, presc_d;
    logic          ovf_q, ovf_d, sat_q, sat_d;
    logic          run, tick, inc_carry, done, down_en;

    // Bit order doubles as priority order: clear (3) > stop > lap > start (0).
    assign btn_raw = {btn_clear, btn_stop, btn_lap, btn_start};
    assign press   = sync2_q & ~prev_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        cmd = CMD_NONE;
        if (press[3])      cmd = CMD_CLEAR;
        else if (press[2]) cmd = CMD_STOP;
        else if (press[1]) cmd = CMD_LAP;
        else if (press[0]) cmd = CMD_START;
    end

    // BCD +1; a carry out of the top digit means the count was all-9s.
    always_comb begin
        inc       = count_q;
        inc_carry = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (inc_carry) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    inc_carry     = 1'b0;
                end
            end
        end
    end

`ifdef CRONO_COUNTDOWN_EN
    logic         down_q, down_d, dec_borrow;
    logic [W-1:0] preset_cl;

    always_comb begin
        dec        = count_q;
        dec_borrow = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (dec_borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec[4*i +: 4] = 4'd9;
                end else begin
                    dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    dec_borrow    = 1'b0;
                end
            end
        end
    end

    always_comb begin
        preset_cl = '0;
        for (int i = 0; i < N_DIGITS; i++)
            preset_cl[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) down_q <= 1'b0;
        else       down_q <= down_d;
    end

    assign down_en = down_q;
`else
    assign dec     = '0;
    assign down_en = 1'b0;
`endif

    always_comb begin
        run     = (state_q == RUN) || (state_q == LAP);
        tick    = run && (presc_q == PW'(TICK_DIV - 1));
        presc_d = presc_q;
        if (run) presc_d = tick ? '0 : presc_q + 1'b1;

        count_d = count_q;
        ovf_d   = 1'b0;
        sat_d   = sat_q;
        done    = 1'b0;
`ifdef CRONO_COUNTDOWN_EN
        down_d  = down_q;
`endif
        // The tick is resolved under the current state before any transition.
        if (tick) begin
            if (down_en) begin
                if (count_q == '0 || dec == '0) begin
                    count_d = '0;
                    ovf_d   = 1'b1;
                    done    = 1'b1;
                end else begin
                    count_d = dec;
                end
            end else if (!inc_carry) begin
                count_d = inc;
            end else if (WRAP_MODE != 0) begin
                count_d = '0;
                ovf_d   = 1'b1;
            end else begin
                ovf_d = !sat_q;
                sat_d = 1'b1;
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE: if (cmd == CMD_START) state_d = RUN;
            RUN: begin
                if (cmd == CMD_LAP)        state_d = LAP;
                else if (cmd == CMD_STOP)  state_d = STOP;
                else if (cmd == CMD_CLEAR) state_d = IDLE;
            end
            LAP: begin
                if (cmd == CMD_LAP)        state_d = RUN;
                else if (cmd == CMD_STOP)  state_d = STOP;
                else if (cmd == CMD_CLEAR) state_d = IDLE;
            end
            STOP: begin
                if (cmd == CMD_START)      state_d = RUN;
                else if (cmd == CMD_CLEAR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done && state_d != IDLE) state_d = STOP;

        digits_d = (state_q == LAP && state_d == LAP) ? digits_q : count_d;

        if (state_d == IDLE) begin
            count_d  = '0;
            digits_d = '0;
            presc_d  = '0;
            sat_d    = 1'b0;
        end
`ifdef CRONO_COUNTDOWN_EN
        else if (state_q == IDLE) begin
            down_d = down_mode;
            if (down_mode) begin
                count_d  = preset_cl;
                digits_d = preset_cl;
            end
        end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            digits_q <= '0;
            presc_q  <= '0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            digits_q <= digits_d;
            presc_q  <= presc_d;
            ovf_q    <= ovf_d;
            sat_q    <= sat_d;
        end
    end

    assign digits = digits_q;
    assign count  = count_q;
    assign state  = state_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_crono_bcd_n.sv
// Bench for crono_bcd_n: three parameter sets share one button bus and are checked
// against an integer-valued reference model plus directed constants.
module tb_crono_bcd_n;
    localparam int K = 3;
    localparam int ND [K] = '{4, 2, 2};
    localparam int TD [K] = '{1, 1, 5};
    localparam int WM [K] = '{1, 0, 1};
    localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_STOP = 3;
    localparam int B_START = 0, B_LAP = 1, B_STOP = 2, B_CLEAR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
`ifdef CRONO_COUNTDOWN_EN
    logic        down_mode;
    logic [15:0] preset;
`endif
    logic [15:0] dig_a, cnt_a;
    logic [7:0]  dig_b, cnt_b, dig_c, cnt_c;
    logic [1:0]  st_a, st_b, st_c;
    logic        ov_a, ov_b, ov_c;

    logic [31:0] o_cnt [K];
    logic [31:0] o_dig [K];
    logic [1:0]  o_st  [K];
    logic        o_ov  [K];

    int n_chk = 0;
    int n_fail = 0;

    // reference model state: counts as plain integers
    int         m_st [K], m_cnt [K], m_dig [K], m_pre [K];
    bit         m_ov [K], m_sat [K], m_dn [K];
    logic [3:0] h1, h2, h3;

    always #5 clk = ~clk;

    crono_bcd_n #(.N_DIGITS(4), .TICK_DIV(1), .WRAP_MODE(1)) dut_a (
        .Clock(clk), .Reset(rst), .btn_start(btn[0]), .btn_lap(btn[1]),
        .btn_stop(btn[2]), .btn_clear(btn[3]),
`ifdef CRONO_COUNTDOWN_EN
        .down_mode(down_mode), .preset(preset),
`endif
        .digits(dig_a), .count(cnt_a), .state(st_a), .ovf(ov_a));

    crono_bcd_n #(.N_DIGITS(2), .TICK_DIV(1), .WRAP_MODE(0)) dut_b (
        .Clock(clk), .Reset(rst), .btn_start(btn[0]), .btn_lap(btn[1]),
        .btn_stop(btn[2]), .btn_clear(btn[3]),
`ifdef CRONO_COUNTDOWN_EN
        .down_mode(down_mode), .preset(preset[7:0]),
`endif
        .digits(dig_b), .count(cnt_b), .state(st_b), .ovf(ov_b));

    crono_bcd_n #(.N_DIGITS(2), .TICK_DIV(5), .WRAP_MODE(1)) dut_c (
        .Clock(clk), .Reset(rst), .btn_start(btn[0]), .btn_lap(btn[1]),
        .btn_stop(btn[2]), .btn_clear(btn[3]),
`ifdef CRONO_COUNTDOWN_EN
        .down_mode(down_mode), .preset(preset[7:0]),
`endif
        .digits(dig_c), .count(cnt_c), .state(st_c), .ovf(ov_c));

    assign o_cnt[0] = {16'h0, cnt_a};
    assign o_cnt[1] = {24'h0, cnt_b};
    assign o_cnt[2] = {24'h0, cnt_c};
    assign o_dig[0] = {16'h0, dig_a};
    assign o_dig[1] = {24'h0, dig_b};
    assign o_dig[2] = {24'h0, dig_c};
    assign o_st[0] = st_a;
    assign o_st[1] = st_b;
    assign o_st[2] = st_c;
    assign o_ov[0] = ov_a;
    assign o_ov[1] = ov_b;
    assign o_ov[2] = ov_c;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] p, input int n);
        int v, w;
        logic [3:0] d;
        v = 0;
        w = 1;
        for (int i = 0; i < n; i++) begin
            d = p[4*i +: 4];
            if (d > 4'd9) d = 4'd9;
            v = v + int'(d) * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < K; j++) begin
            m_st[j] = S_IDLE; m_cnt[j] = 0; m_dig[j] = 0; m_pre[j] = 0;
            m_ov[j] = 0; m_sat[j] = 0; m_dn[j] = 0;
        end
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    // One clock edge of the stopwatch rules; a level seen high two samples
    // ago after being low three samples ago is a press acted on now.
    task automatic model_edge();
        logic [3:0] pr;
        int win, mx, nc, nd, np, ns;
        bit run, tk, ov, done;
        pr = h2 & ~h3;
        win = pr[B_CLEAR] ? B_CLEAR : pr[B_STOP] ? B_STOP : pr[B_LAP] ? B_LAP : pr[B_START] ? B_START : -1;
        for (int j = 0; j < K; j++) begin
            mx = 1;
            for (int i = 0; i < ND[j]; i++) mx = mx * 10;
            mx = mx - 1;
            run = (m_st[j] == S_RUN) || (m_st[j] == S_LAP);
            tk = run && (m_pre[j] == TD[j] - 1);
            np = run ? (tk ? 0 : m_pre[j] + 1) : m_pre[j];
            nc = m_cnt[j]; ov = 0; done = 0;
            if (tk) begin
                if (m_dn[j]) begin
                    nc = (m_cnt[j] > 0) ? m_cnt[j] - 1 : 0;
                    if (nc == 0) begin ov = 1; done = 1; end
                end else if (m_cnt[j] < mx) begin
                    nc = m_cnt[j] + 1;
                end else if (WM[j] != 0) begin
                    nc = 0; ov = 1;
                end else begin
                    ov = !m_sat[j]; m_sat[j] = 1;
                end
            end
            ns = m_st[j];
            case (m_st[j])
                S_IDLE: if (win == B_START) ns = S_RUN;
                S_RUN:  if (win == B_LAP) ns = S_LAP; else if (win == B_STOP) ns = S_STOP; else if (win == B_CLEAR) ns = S_IDLE;
                S_LAP:  if (win == B_LAP) ns = S_RUN; else if (win == B_STOP) ns = S_STOP; else if (win == B_CLEAR) ns = S_IDLE;
                default: if (win == B_START) ns = S_RUN; else if (win == B_CLEAR) ns = S_IDLE;
            endcase
            if (done && ns != S_IDLE) ns = S_STOP;
            nd = (m_st[j] == S_LAP && ns == S_LAP) ? m_dig[j] : nc;
            if (ns == S_IDLE) begin
                nc = 0; nd = 0; np = 0; m_sat[j] = 0;
            end else if (m_st[j] == S_IDLE) begin
`ifdef CRONO_COUNTDOWN_EN
                m_dn[j] = down_mode;
                if (down_mode) begin nc = clamp_val(preset, ND[j]); nd = nc; end
`endif
            end
            m_st[j] = ns; m_cnt[j] = nc; m_dig[j] = nd; m_pre[j] = np; m_ov[j] = ov;
        end
        h3 = h2; h2 = h1; h1 = btn;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic hit(input logic [3:0] m);
        btn = m;
        step(3);
        btn = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = '0;
`ifdef CRONO_COUNTDOWN_EN
        down_mode = 1'b0;
        preset = '0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < K; j++) begin
            n_chk++; if (o_cnt[j] !== 32'h0) begin n_fail++; $display("FAIL reset_cnt[%0d] got %h want 0", j, o_cnt[j]); end
            n_chk++; if (o_dig[j] !== 32'h0) begin n_fail++; $display("FAIL reset_dig[%0d] got %h want 0", j, o_dig[j]); end
            n_chk++; if (o_st[j] !== 2'd0) begin n_fail++; $display("FAIL reset_state[%0d] got %0d want 0", j, o_st[j]); end
            n_chk++; if (o_ov[j] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf[%0d] got %b want 0", j, o_ov[j]); end
        end
        rst = 1'b0;
        step(2);
        n_chk++; if (st_a !== 2'd0) begin n_fail++; $display("FAIL idle_after_reset got %0d want 0", st_a); end
    endtask

    task automatic test_count();
        btn[B_START] = 1'b1;
        step(2);
        n_chk++; if (st_a !== 2'd0) begin n_fail++; $display("FAIL start_latency_early got %0d want 0", st_a); end
        step(1);
        btn = '0;
        n_chk++; if (st_a !== 2'd1) begin n_fail++; $display("FAIL start_latency got %0d want 1", st_a); end
        step(1234);
        n_chk++; if (cnt_a !== 16'h1234) begin n_fail++; $display("FAIL count_1234 got %h want 1234", cnt_a); end
        n_chk++; if (dig_a !== 16'h1234) begin n_fail++; $display("FAIL digits_1234 got %h want 1234", dig_a); end
        step(20);
        n_chk++; if (cnt_a !== 16'h1254) begin n_fail++; $display("FAIL count_1254 got %h want 1254", cnt_a); end
        n_chk++; if (dig_a !== 16'h1254) begin n_fail++; $display("FAIL digits_1254 got %h want 1254", dig_a); end
        for (int j = 1; j < K; j++) begin
            n_chk++; if (o_cnt[j] !== to_bcd(m_cnt[j])) begin n_fail++; $display("FAIL count_model[%0d] got %h want %h", j, o_cnt[j], to_bcd(m_cnt[j])); end
        end
    endtask

    task automatic test_reset_mid();
        hit(4'b1000);
        n_chk++; if (st_a !== 2'd0 || cnt_a !== 16'h0 || dig_a !== 16'h0) begin
            n_fail++; $display("FAIL clear_to_idle got st=%0d cnt=%h dig=%h want 0/0/0", st_a, cnt_a, dig_a); end
        step(1);
        hit(4'b0001);
        step(123);
        n_chk++; if (cnt_a !== 16'h0123) begin n_fail++; $display("FAIL count_0123 got %h want 0123", cnt_a); end
        #2 rst = 1'b1;
        #1;
        for (int j = 0; j < K; j++) begin
            n_chk++; if (o_cnt[j] !== 32'h0 || o_dig[j] !== 32'h0 || o_st[j] !== 2'd0) begin
                n_fail++; $display("FAIL async_reset[%0d] got cnt=%h dig=%h st=%0d want 0/0/0", j, o_cnt[j], o_dig[j], o_st[j]); end
        end
        model_reset();
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_lap();
        hit(4'b0001);
        step(47);
        hit(4'b0010);
        n_chk++; if (st_a !== 2'd2) begin n_fail++; $display("FAIL lap_enter got %0d want 2", st_a); end
        n_chk++; if (dig_a !== 16'h0050 || cnt_a !== 16'h0050) begin n_fail++; $display("FAIL lap_entry_value got dig=%h cnt=%h want 0050", dig_a, cnt_a); end
        step(30);
        n_chk++; if (dig_a !== 16'h0050) begin n_fail++; $display("FAIL lap_hold_digits got %h want 0050", dig_a); end
        n_chk++; if (cnt_a !== 16'h0080) begin n_fail++; $display("FAIL lap_count_runs got %h want 0080", cnt_a); end
        for (int j = 1; j < K; j++) begin
            n_chk++; if (o_dig[j] !== to_bcd(m_dig[j])) begin n_fail++; $display("FAIL lap_dig_model[%0d] got %h want %h", j, o_dig[j], to_bcd(m_dig[j])); end
        end
        btn[B_LAP] = 1'b1;
        step(2);
        n_chk++; if (dig_a !== 16'h0050) begin n_fail++; $display("FAIL lap_release_early got %h want 0050", dig_a); end
        step(1);
        btn = '0;
        n_chk++; if (st_a !== 2'd1 || dig_a !== 16'h0083 || cnt_a !== 16'h0083) begin
            n_fail++; $display("FAIL lap_release got st=%0d dig=%h cnt=%h want 1/0083/0083", st_a, dig_a, cnt_a); end
    endtask

    task automatic test_wrap();
        int nov [K];
        hit(4'b1000);
        step(1);
        hit(4'b0001);
        for (int j = 0; j < K; j++) nov[j] = 0;
        for (int i = 1; i <= 510; i++) begin
            step(1);
            for (int j = 0; j < K; j++) if (o_ov[j]) nov[j]++;
            if (i == 4) begin n_chk++; if (cnt_c !== 8'h00) begin n_fail++; $display("FAIL div5_before got %h want 00", cnt_c); end end
            if (i == 5) begin n_chk++; if (cnt_c !== 8'h01) begin n_fail++; $display("FAIL div5_first got %h want 01", cnt_c); end end
            if (i == 99) begin n_chk++; if (cnt_b !== 8'h99 || ov_b !== 1'b0) begin n_fail++; $display("FAIL sat_reach got %h ovf=%b want 99 ovf=0", cnt_b, ov_b); end end
            if (i == 100) begin n_chk++; if (cnt_b !== 8'h99 || ov_b !== 1'b1) begin n_fail++; $display("FAIL sat_tick got %h ovf=%b want 99 ovf=1", cnt_b, ov_b); end end
            if (i == 495) begin n_chk++; if (cnt_c !== 8'h99 || ov_c !== 1'b0) begin n_fail++; $display("FAIL wrap_reach got %h ovf=%b want 99 ovf=0", cnt_c, ov_c); end end
            if (i == 500) begin n_chk++; if (cnt_c !== 8'h00 || ov_c !== 1'b1) begin n_fail++; $display("FAIL wrap_tick got %h ovf=%b want 00 ovf=1", cnt_c, ov_c); end end
        end
        n_chk++; if (nov[0] != 0) begin n_fail++; $display("FAIL ovf_count_a got %0d want 0", nov[0]); end
        n_chk++; if (nov[1] != 1) begin n_fail++; $display("FAIL ovf_count_sat got %0d want 1", nov[1]); end
        n_chk++; if (nov[2] != 1) begin n_fail++; $display("FAIL ovf_count_wrap got %0d want 1", nov[2]); end
        n_chk++; if (cnt_b !== 8'h99 || st_b !== 2'd1) begin n_fail++; $display("FAIL sat_hold got %h st=%0d want 99 st=1", cnt_b, st_b); end
    endtask

    task automatic test_priority();
        int r;
        hit(4'b1101);
        for (int j = 0; j < K; j++) begin
            n_chk++; if (o_st[j] !== 2'd0 || o_cnt[j] !== 32'h0) begin
                n_fail++; $display("FAIL prio_clear[%0d] got st=%0d cnt=%h want 0/0", j, o_st[j], o_cnt[j]); end
        end
        step(1);
        hit(4'b0001);
        step(34);
        hit(4'b0100);
        n_chk++; if (st_a !== 2'd3 || cnt_a !== 16'h0037 || dig_a !== 16'h0037) begin
            n_fail++; $display("FAIL stop_on_tick got st=%0d cnt=%h dig=%h want 3/0037/0037", st_a, cnt_a, dig_a); end
        n_chk++; if (cnt_c !== 8'h07) begin n_fail++; $display("FAIL stop_div5 got %h want 07", cnt_c); end
        r = $urandom_range(3, 20);
        step(r);
        n_chk++; if (cnt_a !== 16'h0037 || st_a !== 2'd3) begin n_fail++; $display("FAIL stop_frozen got %h st=%0d want 0037 st=3", cnt_a, st_a); end
        for (int j = 0; j < K; j++) begin
            n_chk++; if (o_dig[j] !== to_bcd(m_cnt[j]) || o_cnt[j] !== to_bcd(m_cnt[j])) begin
                n_fail++; $display("FAIL stop_model[%0d] got cnt=%h dig=%h want %h", j, o_cnt[j], o_dig[j], to_bcd(m_cnt[j])); end
        end
        hit(4'b0001);
        n_chk++; if (st_a !== 2'd1 || cnt_a !== 16'h0037) begin n_fail++; $display("FAIL resume got st=%0d cnt=%h want 1/0037", st_a, cnt_a); end
        step(1);
        n_chk++; if (cnt_a !== 16'h0038) begin n_fail++; $display("FAIL resume_inc got %h want 0038", cnt_a); end
        step(1);
        n_chk++; if (cnt_c !== 8'h07) begin n_fail++; $display("FAIL presc_held_early got %h want 07", cnt_c); end
        step(1);
        n_chk++; if (cnt_c !== 8'h08) begin n_fail++; $display("FAIL presc_held got %h want 08", cnt_c); end
    endtask

`ifdef CRONO_COUNTDOWN_EN
    task automatic test_countdown();
        step(2);
        hit(4'b1000);
        down_mode = 1'b1;
        preset = 16'h0012;
        step(1);
        hit(4'b0001);
        n_chk++; if (cnt_a !== 16'h0012 || dig_a !== 16'h0012 || st_a !== 2'd1) begin
            n_fail++; $display("FAIL cd_load got cnt=%h dig=%h st=%0d want 0012/0012/1", cnt_a, dig_a, st_a); end
        for (int i = 1; i <= 12; i++) begin
            step(1);
            n_chk++; if (o_cnt[0] !== to_bcd(12 - i)) begin n_fail++; $display("FAIL cd_count[%0d] got %h want %h", i, cnt_a, to_bcd(12 - i)); end
            n_chk++; if (ov_a !== (i == 12) || st_a !== ((i == 12) ? 2'd3 : 2'd1)) begin
                n_fail++; $display("FAIL cd_done[%0d] got ovf=%b st=%0d", i, ov_a, st_a); end
        end
        down_mode = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 63) == 0) btn[B_CLEAR] = ~btn[B_CLEAR];
`ifdef CRONO_COUNTDOWN_EN
            if ($urandom_range(0, 31) == 0) down_mode = ~down_mode;
            if ($urandom_range(0, 31) == 0) preset = 16'($urandom);
`endif
            step(1);
            for (int j = 0; j < K; j++) begin
                n_chk++; if (o_st[j] !== 2'(m_st[j])) begin n_fail++; $display("FAIL rnd_state[%0d] c=%0d got %0d want %0d", j, c, o_st[j], m_st[j]); end
                n_chk++; if (o_cnt[j] !== to_bcd(m_cnt[j])) begin n_fail++; $display("FAIL rnd_count[%0d] c=%0d got %h want %h", j, c, o_cnt[j], to_bcd(m_cnt[j])); end
                n_chk++; if (o_dig[j] !== to_bcd(m_dig[j])) begin n_fail++; $display("FAIL rnd_digits[%0d] c=%0d got %h want %h", j, c, o_dig[j], to_bcd(m_dig[j])); end
                n_chk++; if (o_ov[j] !== m_ov[j]) begin n_fail++; $display("FAIL rnd_ovf[%0d] c=%0d got %b want %b", j, c, o_ov[j], m_ov[j]); end
            end
        end
        btn = '0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_reset_mid();
        test_lap();
        test_wrap();
        test_priority();
`ifdef CRONO_COUNTDOWN_EN
        test_countdown();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
